// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder
//
// Sequential priority encoder. It accepts a WIDTH-bit request vector over a
// valid/ready handshake. It then emits the index of every set bit, one per
// output beat, in priority order:
//   - MSB_FIRST=0: lowest index first.
//   - MSB_FIRST=1: highest index first.
// Each beat carries last/none flags and the popcount of the accepted vector.
// Input acceptance and output scanning never overlap. A new vector is taken
// only in IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_vec     request vector, sampled on in_valid && in_ready
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (IDLE and no flush this cycle)
//   flush      synchronous abort of the current scan
//   out_idx    index of the current highest-priority pending bit
//   out_none   current beat stands for an all-zero input vector
//   out_last   current beat is the final beat of this vector
//   out_count  popcount of the accepted vector, constant across its beats
//   out_valid  output beat is valid
//   out_ready  downstream accepts the beat
module priority_scan_encoder #(
   parameter int WIDTH     = 8,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_none,
   output logic             out_last,
   output logic [IDX_W:0]   out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pend, pend_nxt;
   logic [IDX_W:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_bit;
   logic             pend_zero;
   logic             pend_one;
   logic             scan;
   logic             take;

   // Index of the priority-selected set bit; 0 when nothing is pending.
   function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++)
            if (v[i]) r = IDX_W'(i);
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Number of set bits. The IDX_W+1 width holds WIDTH exactly.
   function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++)
         c = c + (IDX_W + 1)'(v[i]);
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      sel_idx   = pick(pend);
      sel_bit   = ONE << sel_idx;
      pend_zero = (pend == '0);
      // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
      pend_one  = !pend_zero && ((pend & (pend - ONE)) == '0);
      scan      = (state == SCAN);

      // A zero vector is a single beat that is both "none" and "last".
      in_ready  = (state == IDLE) && !flush;
      out_valid = scan;
      out_idx   = sel_idx;
      out_none  = scan && pend_zero;
      out_last  = scan && (pend_one || pend_zero);
      out_count = cnt;
      take      = in_valid && in_ready;

      state_nxt = state;
      pend_nxt  = pend;
      cnt_nxt   = cnt;

      case (state)
         IDLE: begin
            if (take) begin
               state_nxt = SCAN;
               pend_nxt  = in_vec;
               cnt_nxt   = popcount(in_vec);
            end
         end
         SCAN: begin
            // flush wins over a simultaneous handshake. That beat still counts
            // as delivered downstream, and nothing further is emitted.
            if (flush) begin
               state_nxt = IDLE;
               pend_nxt  = '0;
            end else if (out_ready) begin
               pend_nxt = pend & ~sel_bit;
               if (out_last) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            pend_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, flush, out_ready;
   logic [7:0] in_vec;

   logic       rdy0, rdy1, val0, val1, none0, none1, last0, last1;
   logic [2:0] idx0, idx1;
   logic [3:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;

   priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
      .in_ready(rdy0), .flush(flush), .out_idx(idx0), .out_none(none0),
      .out_last(last0), .out_count(cnt0), .out_valid(val0), .out_ready(out_ready));

   priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
      .in_ready(rdy1), .flush(flush), .out_idx(idx1), .out_none(none1),
      .out_last(last1), .out_count(cnt1), .out_valid(val1), .out_ready(out_ready));

   // Reference model: the expected index sequence for each priority order.
   function automatic void make_exp(input logic [7:0] v);
      q0.delete();
      q1.delete();
      for (int i = 0; i < 8; i++) if (v[i]) q0.push_back(i);
      for (int i = 7; i >= 0; i--) if (v[i]) q1.push_back(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [7:0] v);
      in_vec   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_vec   = 8'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_vec = '0;
      tick(); tick();
      total++;
      if ({val0, none0, last0, idx0, cnt0, val1, none1, last1, idx1, cnt1} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b n=%b l=%b i=%0d c=%0d expected all 0", val0, none0, last0, idx0, cnt0);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got %b/%b expected 1", rdy0, rdy1);
      end
   endtask

   task automatic test_order();
      logic [7:0] v = 8'b1010_0110;
      make_exp(v);
      out_ready = 1'b1;
      accept(v);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (val0 !== 1'b1 || idx0 !== 3'(q0[k]) || last0 !== (k == 3) || cnt0 !== 4'd4 || none0 !== 1'b0) begin
            bad++;
            $display("FAIL order_lsb beat %0d got v=%b i=%0d l=%b c=%0d expected i=%0d l=%b c=4", k, val0, idx0, last0, cnt0, q0[k], k == 3);
         end
         total++;
         if (val1 !== 1'b1 || idx1 !== 3'(q1[k]) || last1 !== (k == 3) || cnt1 !== 4'd4 || none1 !== 1'b0) begin
            bad++;
            $display("FAIL order_msb beat %0d got v=%b i=%0d l=%b c=%0d expected i=%0d l=%b c=4", k, val1, idx1, last1, cnt1, q1[k], k == 3);
         end
         tick();
      end
      total++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0 || rdy1 !== 1'b1) begin
         bad++;
         $display("FAIL order_done got valid=%b ready=%b expected valid=0 ready=1", val0, rdy0);
      end
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      accept(8'h00);
      total++;
      if (val0 !== 1'b1 || none0 !== 1'b1 || last0 !== 1'b1 || idx0 !== 3'd0 || cnt0 !== 4'd0 || rdy0 !== 1'b0) begin
         bad++;
         $display("FAIL zero_beat got v=%b n=%b l=%b i=%0d c=%0d r=%b expected 1 1 1 0 0 0", val0, none0, last0, idx0, cnt0, rdy0);
      end
      total++;
      if (val1 !== 1'b1 || none1 !== 1'b1 || last1 !== 1'b1 || idx1 !== 3'd0 || cnt1 !== 4'd0) begin
         bad++;
         $display("FAIL zero_beat_msb got v=%b n=%b l=%b i=%0d c=%0d expected 1 1 1 0 0", val1, none1, last1, idx1, cnt1);
      end
      tick();
      total++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
         bad++;
         $display("FAIL zero_done got valid=%b ready=%b expected valid=0 ready=1", val0, rdy0);
      end
   endtask

   task automatic test_stall();
      bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int         n = 0;
      int         cyc = 0;
      bit         prev_stall = 1'b0;
      logic [2:0] pi0, pi1;
      make_exp(8'hFF);
      out_ready = 1'b0;
      accept(8'hFF);
      while (n < 8 && cyc < 100) begin
         out_ready = pat[cyc % 4];
         if (prev_stall) begin
            total++;
            if (idx0 !== pi0 || idx1 !== pi1 || cnt0 !== 4'd8 || val0 !== 1'b1) begin
               bad++;
               $display("FAIL stall_hold cyc %0d got i=%0d/%0d c=%0d v=%b expected i=%0d/%0d c=8 v=1", cyc, idx0, idx1, cnt0, val0, pi0, pi1);
            end
         end
         if (val0 && out_ready) begin
            total++;
            if (idx0 !== 3'(q0[n]) || idx1 !== 3'(q1[n]) || last0 !== (n == 7) || last1 !== (n == 7) || cnt0 !== 4'd8 || cnt1 !== 4'd8) begin
               bad++;
               $display("FAIL stall_beat %0d got i=%0d/%0d l=%b c=%0d expected i=%0d/%0d l=%b c=8", n, idx0, idx1, last0, cnt0, q0[n], q1[n], n == 7);
            end
            n++;
         end
         prev_stall = val0 && !out_ready;
         pi0 = idx0;
         pi1 = idx1;
         tick();
         cyc++;
      end
      total++;
      if (n != 8 || val0 !== 1'b0 || rdy0 !== 1'b1) begin
         bad++;
         $display("FAIL stall_count got beats=%0d valid=%b expected beats=8 valid=0", n, val0);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      accept(8'b0011_1000);
      total++;
      if (val0 !== 1'b1 || idx0 !== 3'd3 || idx1 !== 3'd5 || cnt0 !== 4'd3) begin
         bad++;
         $display("FAIL flush_first got v=%b i=%0d/%0d c=%0d expected v=1 i=3/5 c=3", val0, idx0, idx1, cnt0);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      total++;
      if (val0 !== 1'b0 || val1 !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
         bad++;
         $display("FAIL flush_stop got valid=%b/%b ready=%b expected valid=0 ready=1", val0, val1, rdy0);
      end
      tick();
      total++;
      if (val0 !== 1'b0 || val1 !== 1'b0) begin
         bad++;
         $display("FAIL flush_residual got valid=%b/%b expected 0", val0, val1);
      end
      accept(8'h01);
      total++;
      if (val0 !== 1'b1 || idx0 !== 3'd0 || last0 !== 1'b1 || idx1 !== 3'd0 || last1 !== 1'b1 || cnt0 !== 4'd1) begin
         bad++;
         $display("FAIL flush_next got v=%b i=%0d l=%b c=%0d expected v=1 i=0 l=1 c=1", val0, idx0, last0, cnt0);
      end
      tick();
   endtask

   task automatic test_flush_idle();
      flush = 1'b1;
      in_valid = 1'b1;
      in_vec = 8'h0F;
      #1;
      total++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle_ready got %b/%b expected 0", rdy0, rdy1);
      end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      total++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
         bad++;
         $display("FAIL flush_idle_accept got valid=%b ready=%b expected valid=0 ready=1", val0, rdy0);
      end
   endtask

   task automatic test_reset_midscan();
      out_ready = 1'b1;
      accept(8'hF0);
      tick();
      rst_n = 1'b0;
      tick();
      total++;
      if ({val0, none0, last0, idx0, cnt0, val1, none1, last1, idx1, cnt1} !== '0) begin
         bad++;
         $display("FAIL midreset_outputs got v=%b n=%b l=%b i=%0d c=%0d expected all 0", val0, none0, last0, idx0, cnt0);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
         bad++;
         $display("FAIL midreset_ready got %b/%b expected 1", rdy0, rdy1);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (val0 !== 1'b0 || val1 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_residual cyc %0d got valid=%b/%b expected 0", k, val0, val1);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         logic [7:0] v;
         int n = 0;
         int cyc = 0;
         int len;
         v = (t == 0) ? 8'h00 : (t == 1) ? 8'hFF : 8'($urandom);
         if (t % 7 == 3) v = 8'h00;
         make_exp(v);
         len = q0.size();
         accept(v);
         while (n < ((len == 0) ? 1 : len) && cyc < 200) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (val0 && out_ready) begin
               total++;
               if (idx0 !== ((len == 0) ? 3'd0 : 3'(q0[n])) || idx1 !== ((len == 0) ? 3'd0 : 3'(q1[n])) ||
                   last0 !== (n == len - 1 || len == 0) || last1 !== (n == len - 1 || len == 0) ||
                   none0 !== (len == 0) || cnt0 !== 4'($countones(v)) || cnt1 !== 4'($countones(v))) begin
                  bad++;
                  $display("FAIL random vec %h beat %0d got i=%0d/%0d l=%b n=%b c=%0d expected c=%0d len=%0d",
                           v, n, idx0, idx1, last0, none0, cnt0, $countones(v), len);
               end
               n++;
            end
            tick();
            cyc++;
         end
         total++;
         if (cyc >= 200 || val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0) begin
            bad++;
            $display("FAIL random_end vec %h got valid=%b ready=%b cycles=%0d expected valid=0 ready=1", v, val0, rdy0, cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_zero();
      test_stall();
      test_flush();
      test_flush_idle();
      test_reset_midscan();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
